// File: rtl/imm_gen_pkg.sv
// =============================================================================
// Module      : imm_gen_pkg
// Description : Shared widths and immediate-format select encodings for the
//               RV32I immediate generator.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package imm_gen_pkg;

    localparam int XLEN  = 32;
    localparam int SEL_W = 3;

    localparam logic [SEL_W-1:0] IMM_I     = 3'd0;
    localparam logic [SEL_W-1:0] IMM_S     = 3'd1;
    localparam logic [SEL_W-1:0] IMM_B     = 3'd2;
    localparam logic [SEL_W-1:0] IMM_U     = 3'd3;
    localparam logic [SEL_W-1:0] IMM_J     = 3'd4;
    localparam logic [SEL_W-1:0] IMM_SHAMT = 3'd5;
    localparam logic [SEL_W-1:0] IMM_ZIMM  = 3'd6;
    localparam logic [SEL_W-1:0] IMM_RSVD  = 3'd7;

endpackage : imm_gen_pkg

`default_nettype wire

// File: rtl/imm_gen_decode.sv
// =============================================================================
// Module      : imm_gen_decode
// Description : Combinational RV32I immediate format mux (instruction, select
//               -> assembled 32-bit immediate).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module imm_gen_decode
    import imm_gen_pkg::*;
(
    input  logic [XLEN-1:0]  ins_i,
    input  logic [SEL_W-1:0] sel_i,
    output logic [XLEN-1:0]  imm_o
);

    // Sign always comes from bit 31; the opcode field is deliberately ignored.
    logic       w_sign;
    logic       w_unused_opcode;

    assign w_sign          = ins_i[31];
    assign w_unused_opcode = ^ins_i[6:0];

    always_comb begin
        imm_o = '0;
        case (sel_i)
            IMM_I:     imm_o = {{20{w_sign}}, ins_i[31:20]};
            IMM_S:     imm_o = {{20{w_sign}}, ins_i[31:25], ins_i[11:7]};
            IMM_B:     imm_o = {{19{w_sign}}, ins_i[31], ins_i[7],
                                ins_i[30:25], ins_i[11:8], 1'b0};
            IMM_U:     imm_o = {ins_i[31:12], 12'b0};
            IMM_J:     imm_o = {{11{w_sign}}, ins_i[31], ins_i[19:12],
                                ins_i[20], ins_i[30:21], 1'b0};
            IMM_SHAMT: imm_o = {27'b0, ins_i[24:20]};
            IMM_ZIMM:  imm_o = {27'b0, ins_i[19:15]};
            IMM_RSVD:  imm_o = '0;
            default:   imm_o = '0;
        endcase
    end

endmodule : imm_gen_decode

`default_nettype wire

// File: rtl/imm_gen.sv
// =============================================================================
// Module      : imm_gen
// Description : RV32I immediate generator with one registered pipeline stage
//               and valid qualifier. Optional macro IMM_GEN_SEL_ERR_EN adds
//               o_sel_err, flagging the reserved select.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module imm_gen
    import imm_gen_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [XLEN-1:0]  i_instruction,
    input  logic [SEL_W-1:0] i_sel,
`ifdef IMM_GEN_SEL_ERR_EN
    output logic             o_sel_err,
`endif
    output logic             o_valid,
    output logic [XLEN-1:0]  o_dataout
);

    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] dataout_d;
    logic [XLEN-1:0] dataout_q;
    logic            valid_q;

    imm_gen_decode u_decode (
        .ins_i (i_instruction),
        .sel_i (i_sel),
        .imm_o (w_imm)
    );

    // Data holds when no new input is offered; valid drops.
    assign dataout_d = i_valid ? w_imm : dataout_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            dataout_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            dataout_q <= dataout_d;
            valid_q   <= i_valid;
        end
    end

    assign o_dataout = dataout_q;
    assign o_valid   = valid_q;

`ifdef IMM_GEN_SEL_ERR_EN
    logic sel_err_d;
    logic sel_err_q;

    assign sel_err_d = i_valid && (i_sel == IMM_RSVD);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign o_sel_err = sel_err_q;
`endif

endmodule : imm_gen

`default_nettype wire

// File: tb/tb_imm_gen.sv
// =============================================================================
// Module      : tb_imm_gen
// Description : Directed and random self-checking bench for imm_gen.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_imm_gen;

    logic        i_clk;
    logic        i_rst;
    logic        i_valid;
    logic [31:0] i_instruction;
    logic [2:0]  i_sel;
    logic        o_valid;
    logic [31:0] o_dataout;
`ifdef IMM_GEN_SEL_ERR_EN
    logic        o_sel_err;
`endif

    int n_tests;
    int n_fail;

    imm_gen dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_valid       (i_valid),
        .i_instruction (i_instruction),
        .i_sel         (i_sel),
`ifdef IMM_GEN_SEL_ERR_EN
        .o_sel_err     (o_sel_err),
`endif
        .o_valid       (o_valid),
        .o_dataout     (o_dataout)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference built with arithmetic shifts and masks rather than a format mux.
    function automatic logic [31:0] ref_imm(input logic [31:0] ins, input logic [2:0] sel);
        logic [31:0] sx;
        sx = ins[31] ? 32'hFFFF_FFFF : 32'h0;
        case (sel)
            3'd0: return 32'($signed(ins) >>> 20);
            3'd1: return (32'($signed(ins) >>> 20) & 32'hFFFF_FFE0) | ((ins >> 7) & 32'h1F);
            3'd2: return (sx & 32'hFFFF_F000) | ((ins & 32'h80) << 4)
                         | ((ins >> 20) & 32'h7E0) | ((ins >> 7) & 32'h1E);
            3'd3: return ins & 32'hFFFF_F000;
            3'd4: return (sx & 32'hFFF0_0000) | (ins & 32'h000F_F000)
                         | ((ins >> 9) & 32'h800) | ((ins >> 20) & 32'h7FE);
            3'd5: return (ins >> 20) & 32'h1F;
            3'd6: return (ins >> 15) & 32'h1F;
            default: return 32'h0;
        endcase
    endfunction

    // Drive one input set, then sample shortly after the capturing edge.
    task automatic step(input logic v, input logic [31:0] ins, input logic [2:0] sel);
        @(negedge i_clk);
        i_valid       = v;
        i_instruction = ins;
        i_sel         = sel;
        @(posedge i_clk);
        #1;
    endtask

    // An unknown select with valid high is an illegal stimulus.
    always @(posedge i_clk) begin
        if (!i_rst && i_valid === 1'b1 && $isunknown(i_sel)) begin
            n_tests++;
            n_fail++;
            $display("FAIL sel_x: got %b expected known select", i_sel);
        end
    end

    logic [31:0] sweep_exp [8];
    logic [31:0] ins_r;
    logic [2:0]  sel_r;
    logic [31:0] hold_val;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        sweep_exp[0] = 32'h0000_0123;
        sweep_exp[1] = 32'h0000_0122;
        sweep_exp[2] = 32'h0000_0122;
        sweep_exp[3] = 32'h1235_3000;
        sweep_exp[4] = 32'h0005_3922;
        sweep_exp[5] = 32'h0000_0003;
        sweep_exp[6] = 32'h0000_000A;
        sweep_exp[7] = 32'h0000_0000;

        i_rst = 1'b1;
        i_valid = 1'b0;
        i_instruction = '0;
        i_sel = '0;
        repeat (2) @(posedge i_clk);
        #1;
        check("reset_data", o_dataout, 32'h0);
        check("reset_valid", {31'b0, o_valid}, 32'h0);
        @(negedge i_clk);
        i_rst = 1'b0;

        for (int s = 0; s < 8; s++) begin
            step(1'b1, 32'h1235_3112, 3'(s));
            check($sformatf("sweep_sel%0d", s), o_dataout, sweep_exp[s]);
            check($sformatf("sweep_valid%0d", s), {31'b0, o_valid}, 32'h1);
`ifdef IMM_GEN_SEL_ERR_EN
            check($sformatf("sel_err%0d", s), {31'b0, o_sel_err}, (s == 7) ? 32'h1 : 32'h0);
`endif
        end

        step(1'b1, 32'hFFF0_0093, 3'd0);
        check("sext_I", o_dataout, 32'hFFFF_FFFF);
        step(1'b1, 32'h8000_0063, 3'd2);
        check("sext_B", o_dataout, 32'hFFFF_F000);
        step(1'b1, 32'h8000_00EF, 3'd4);
        check("sext_J", o_dataout, 32'hFFF0_0000);
        step(1'b1, 32'hFE00_0FA3, 3'd1);
        check("sext_S", o_dataout, 32'hFFFF_FFFF);

        step(1'b1, 32'hABCD_E000, 3'd3);
        check("pipe1_data", o_dataout, 32'hABCD_E000);
        check("pipe1_valid", {31'b0, o_valid}, 32'h1);
        step(1'b0, 32'h1234_5678, 3'd3);
        check("pipe0_hold", o_dataout, 32'hABCD_E000);
        check("pipe0_valid", {31'b0, o_valid}, 32'h0);
`ifdef IMM_GEN_SEL_ERR_EN
        step(1'b0, 32'h0, 3'd7);
        check("sel_err_novalid", {31'b0, o_sel_err}, 32'h0);
`endif
        step(1'b1, 32'h0010_0000, 3'd3);
        check("pipe2_data", o_dataout, 32'h0010_0000);
        check("pipe2_valid", {31'b0, o_valid}, 32'h1);

        for (int k = 0; k < 1000; k++) begin
            ins_r = $urandom;
            sel_r = 3'($urandom_range(0, 7));
            step(1'b1, ins_r, sel_r);
            check($sformatf("rand%0d_s%0d", k, sel_r), o_dataout, ref_imm(ins_r, sel_r));
            check($sformatf("rand%0d_v", k), {31'b0, o_valid}, 32'h1);
            if (sel_r == 3'd2 || sel_r == 3'd4)
                check($sformatf("rand%0d_lsb", k), {31'b0, o_dataout[0]}, 32'h0);
        end

        // Asynchronous reset mid-cycle with a live result in the register.
        step(1'b1, 32'hFFF0_0093, 3'd0);
        hold_val = o_dataout;
        check("pre_rst_data", hold_val, 32'hFFFF_FFFF);
        #2;
        i_rst = 1'b1;
        #1;
        check("async_rst_data", o_dataout, 32'h0);
        check("async_rst_valid", {31'b0, o_valid}, 32'h0);
        @(posedge i_clk);
        #1;
        check("rst_hold_data", o_dataout, 32'h0);
        check("rst_hold_valid", {31'b0, o_valid}, 32'h0);
        @(negedge i_clk);
        i_rst = 1'b0;
        step(1'b1, 32'h1235_3112, 3'd4);
        check("post_rst_data", o_dataout, 32'h0005_3922);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_imm_gen

`default_nettype wire
